// File: rtl/fuzzy_pkg.sv
// Shared types and helpers for the interval type-2 fuzzy processor datapath.
// Holds the scheduler state encoding, grid size and rule-code packing.
package fuzzy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LIMPA = 2'd1,
        VARRE = 2'd2,
        FIM   = 2'd3
    } estado_t;

    localparam int N_PERT  = 3;
    localparam int W_REGRA = 4;

    // Rule code is the two membership indices concatenated, input 1 in the high half.
    function automatic logic [W_REGRA-1:0] empacota_regra(input logic [1:0] i, input logic [1:0] j);
        return {i, j};
    endfunction

endpackage

// File: rtl/escalonador_regras_if.sv
// Start/abort/mask inputs and rule-code outputs of the rule scheduler.
// The master side (fuzzification/control) drives requests; the slave is the scheduler.
interface escalonador_regras_if;
    logic       inicio;
    logic       aborta;
    logic [5:0] Ativo;
    logic [3:0] regra;
    logic       regra_valida;
    logic       reset_inf;
    logic       ocupado;
    logic       fim;

    modport master (
        output inicio, aborta, Ativo,
        input  regra, regra_valida, reset_inf, ocupado, fim
    );

    modport slave (
        input  inicio, aborta, Ativo,
        output regra, regra_valida, reset_inf, ocupado, fim
    );
endinterface

// File: rtl/busca_prox_par.sv
// Combinational finder for the next eligible (i,j) pair strictly after the
// current one in row-major order over the 3x3 rule grid.
module busca_prox_par
    import fuzzy_pkg::*;
(
    input  logic [2*N_PERT-1:0] mask_r,
    input  logic [1:0]          i_atual,
    input  logic [1:0]          j_atual,
    output logic                encontrado,
    output logic [1:0]          i_prox,
    output logic [1:0]          j_prox
);

    logic [N_PERT*N_PERT-1:0] elegivel;
    logic [3:0]               pos_atual;

    generate
        for (genvar gi = 0; gi < N_PERT; gi++) begin : g_linha
            for (genvar gj = 0; gj < N_PERT; gj++) begin : g_coluna
                assign elegivel[gi*N_PERT+gj] = mask_r[gi] & mask_r[N_PERT+gj];
            end
        end
    endgenerate

    assign pos_atual = 4'(i_atual) * 4'(N_PERT) + 4'(j_atual);

    // Scanning from the top down lets the lowest later position win.
    always_comb begin
        encontrado = 1'b0;
        i_prox     = i_atual;
        j_prox     = j_atual;
        for (int k = N_PERT*N_PERT-1; k >= 0; k--) begin
            if (elegivel[k] && (4'(k) > pos_atual)) begin
                encontrado = 1'b1;
                i_prox     = 2'(k / N_PERT);
                j_prox     = 2'(k % N_PERT);
            end
        end
    end

endmodule

// File: rtl/escalonador_regras.sv
// Rule scheduler: walks the 3x3 rule grid, holding each code CICLOS_REGRA cycles.
// Define ESCALONADOR_SALTO_EN to skip pairs whose memberships are inactive.
module escalonador_regras
    import fuzzy_pkg::*;
#(
    parameter int unsigned CICLOS_REGRA = 2
) (
    input logic                  clk_0,
    input logic                  Srst,
    escalonador_regras_if.slave  bus
);

    localparam logic [3:0] ULTIMO = 4'(CICLOS_REGRA - 1);

    estado_t      estado_q, estado_d;
    logic [5:0]   mask_q, mask_d;
    logic [5:0]   mask_eff;
    logic [1:0]   i_q, i_d, j_q, j_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [W_REGRA-1:0] regra_q, regra_d;
    logic         valida_q, valida_d;
    logic         reset_inf_q, reset_inf_d;
    logic         ocupado_q, ocupado_d;
    logic         fim_q, fim_d;

    logic         encontrado;
    logic [1:0]   i_prox, j_prox;
    logic         primeiro_elegivel;

`ifdef ESCALONADOR_SALTO_EN
    assign mask_eff = mask_q;
`else
    assign mask_eff = mask_q | 6'h3F;
`endif

    // The finder only looks past the current pair, so (0,0) is tested directly in LIMPA.
    assign primeiro_elegivel = mask_eff[0] & mask_eff[N_PERT];

    busca_prox_par u_busca (
        .mask_r     (mask_eff),
        .i_atual    (i_q),
        .j_atual    (j_q),
        .encontrado (encontrado),
        .i_prox     (i_prox),
        .j_prox     (j_prox)
    );

    always_comb begin
        estado_d = estado_q;
        mask_d   = mask_q;
        i_d      = i_q;
        j_d      = j_q;
        cnt_d    = cnt_q;
        case (estado_q)
            IDLE: begin
                if (bus.inicio && !bus.aborta) begin
                    mask_d   = bus.Ativo;
                    i_d      = 2'd0;
                    j_d      = 2'd0;
                    cnt_d    = 4'd0;
                    estado_d = LIMPA;
                end
            end
            LIMPA: begin
                cnt_d = 4'd0;
                if (primeiro_elegivel) begin
                    estado_d = VARRE;
                end else if (encontrado) begin
                    i_d      = i_prox;
                    j_d      = j_prox;
                    estado_d = VARRE;
                end else begin
                    estado_d = FIM;
                end
            end
            VARRE: begin
                if (cnt_q == ULTIMO) begin
                    cnt_d = 4'd0;
                    if (encontrado) begin
                        i_d = i_prox;
                        j_d = j_prox;
                    end else begin
                        estado_d = FIM;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            FIM: begin
                estado_d = IDLE;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
        if ((estado_q != IDLE) && bus.aborta) begin
            estado_d = IDLE;
            cnt_d    = 4'd0;
        end
    end

    // Outputs are decoded from the next state so they appear registered with the state.
    always_comb begin
        regra_d     = '0;
        valida_d    = 1'b0;
        reset_inf_d = 1'b0;
        ocupado_d   = 1'b0;
        fim_d       = 1'b0;
        case (estado_d)
            LIMPA: begin
                reset_inf_d = 1'b1;
                ocupado_d   = 1'b1;
            end
            VARRE: begin
                valida_d  = 1'b1;
                ocupado_d = 1'b1;
                regra_d   = empacota_regra(i_d, j_d);
            end
            FIM: begin
                fim_d     = 1'b1;
                ocupado_d = 1'b1;
            end
            default: begin
                regra_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_0 or posedge Srst) begin
        if (Srst) begin
            estado_q    <= IDLE;
            mask_q      <= '0;
            i_q         <= '0;
            j_q         <= '0;
            cnt_q       <= '0;
            regra_q     <= '0;
            valida_q    <= 1'b0;
            reset_inf_q <= 1'b0;
            ocupado_q   <= 1'b0;
            fim_q       <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            mask_q      <= mask_d;
            i_q         <= i_d;
            j_q         <= j_d;
            cnt_q       <= cnt_d;
            regra_q     <= regra_d;
            valida_q    <= valida_d;
            reset_inf_q <= reset_inf_d;
            ocupado_q   <= ocupado_d;
            fim_q       <= fim_d;
        end
    end

    assign bus.regra        = regra_q;
    assign bus.regra_valida = valida_q;
    assign bus.reset_inf    = reset_inf_q;
    assign bus.ocupado      = ocupado_q;
    assign bus.fim          = fim_q;

endmodule

// File: tb/tb_escalonador_regras.sv
// Directed + randomized bench for escalonador_regras against a list-of-rules model.
// Follows the ESCALONADOR_SALTO_EN build setting of the design.
module tb_escalonador_regras;

    localparam int C = 2;
`ifdef ESCALONADOR_SALTO_EN
    localparam bit SALTO = 1'b1;
`else
    localparam bit SALTO = 1'b0;
`endif

    logic clk_0;
    logic Srst;
    int   total;
    int   bad;

    escalonador_regras_if bus_if ();

    escalonador_regras #(.CICLOS_REGRA(C)) dut (
        .clk_0 (clk_0),
        .Srst  (Srst),
        .bus   (bus_if)
    );

    initial clk_0 = 1'b0;
    always #5 clk_0 = ~clk_0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " regra"},        bus_if.regra,               4'h0);
        chk({tag, " regra_valida"}, {3'b0, bus_if.regra_valida}, 4'h0);
        chk({tag, " reset_inf"},    {3'b0, bus_if.reset_inf},    4'h0);
        chk({tag, " ocupado"},      {3'b0, bus_if.ocupado},      4'h0);
        chk({tag, " fim"},          {3'b0, bus_if.fim},          4'h0);
    endtask

    // Called at a negedge in IDLE: requests a scan and checks every cycle up to the idle one after fim.
    task automatic scan(input logic [5:0] m, input bit perturba);
        int    codes[$];
        int    f;
        bit    ev;
        string t;
        codes = {};
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                if (!SALTO || (m[i] && m[3+j])) codes.push_back(i*4 + j);
        f = 2 + codes.size() * C;
        bus_if.Ativo  = m;
        bus_if.inicio = 1'b1;
        for (int c = 1; c <= f + 1; c++) begin
            @(negedge clk_0);
            if (c == 1) bus_if.inicio = 1'b0;
            t  = $sformatf("mask=%b cyc=%0d", m, c);
            ev = (c >= 2) && (c < f);
            chk({t, " reset_inf"},    {3'b0, bus_if.reset_inf},    {3'b0, (c == 1)});
            chk({t, " ocupado"},      {3'b0, bus_if.ocupado},      {3'b0, (c <= f)});
            chk({t, " fim"},          {3'b0, bus_if.fim},          {3'b0, (c == f)});
            chk({t, " regra_valida"}, {3'b0, bus_if.regra_valida}, {3'b0, ev});
            if (ev) chk({t, " regra"}, bus_if.regra, 4'(codes[(c-2)/C]));
            if (c == f + 1) chk({t, " regra idle"}, bus_if.regra, 4'h0);
            if (perturba && f >= 6) begin
                if (c == 5) begin
                    bus_if.Ativo  = ~m;
                    bus_if.inicio = 1'b1;
                end
                if (c == 6) bus_if.inicio = 1'b0;
            end
        end
        bus_if.Ativo = m;
        $display("scan mask=%b perturba=%0d N=%0d fim_cycle=%0d", m, perturba, codes.size(), f);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Srst  = 1'b1;
        bus_if.inicio = 1'b0;
        bus_if.aborta = 1'b0;
        bus_if.Ativo  = 6'h00;
        @(negedge clk_0);
        @(negedge clk_0);
        chk_idle("reset held");
        Srst = 1'b0;
        @(negedge clk_0);
        chk_idle("after reset");

        scan(6'b111111, 1'b0);
        scan(6'b010011, 1'b0);
        scan(6'b000111, 1'b0);
        scan(6'b111111, 1'b1);
        scan(6'b010011, 1'b1);
        repeat (8) scan(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));

        // inicio together with aborta in IDLE must not start a scan
        bus_if.inicio = 1'b1;
        bus_if.aborta = 1'b1;
        @(negedge clk_0);
        bus_if.inicio = 1'b0;
        bus_if.aborta = 1'b0;
        chk_idle("inicio+aborta idle");
        $display("inicio+aborta in IDLE");

        // Abort during cycle 7, restart in cycle 9
        bus_if.Ativo  = 6'h3F;
        bus_if.inicio = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk_0);
            if (c == 1) bus_if.inicio = 1'b0;
        end
        chk("abort cyc7 regra_valida", {3'b0, bus_if.regra_valida}, 4'h1);
        chk("abort cyc7 regra", bus_if.regra, 4'h2);
        bus_if.aborta = 1'b1;
        @(negedge clk_0);
        bus_if.aborta = 1'b0;
        chk_idle("abort cyc8");
        @(negedge clk_0);
        chk_idle("abort cyc9");
        $display("abort at cycle 7, restart at cycle 9");
        scan(6'h3F, 1'b0);

        // Async reset between edges in cycle 4
        bus_if.Ativo  = 6'h3F;
        bus_if.inicio = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_0);
            if (c == 1) bus_if.inicio = 1'b0;
        end
        chk("srst pre regra_valida", {3'b0, bus_if.regra_valida}, 4'h1);
        Srst = 1'b1;
        #1;
        chk("srst async regra_valida", {3'b0, bus_if.regra_valida}, 4'h0);
        chk("srst async ocupado",      {3'b0, bus_if.ocupado},      4'h0);
        chk("srst async regra",        bus_if.regra,                4'h0);
        @(negedge clk_0);
        Srst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_0);
            chk_idle($sformatf("post srst %0d", c));
        end
        $display("async reset mid-rule");

        scan(6'b101101, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/escalonador_regras.md
# escalonador_regras

Rule scheduler for the interval type-2 fuzzy processor. It sits between the fuzzification stage and the inference/accumulation stage. On each start request it latches the membership-activity mask. It then walks the 3×3 rule grid in a fixed order and presents one `{sel_1, sel_2}` rule code at a time to inference, holding each code for a programmable number of cycles. It brackets the scan with an accumulator-clear pulse at the start and a done pulse at the end.

## Interface
- `CICLOS_REGRA`, default 2: cycles each rule code is held valid; legal range 1..15.
- `clk_0`  in  1: system clock; all state changes on the rising edge.
- `Srst`  in  1: reset, asynchronous, active-high.
- `inicio`  in  1: start request; sampled only in IDLE.
- `aborta`  in  1: synchronous abort; returns the block to IDLE.
- `Ativo`  in  6: activity mask.
  - Bits [2:0]: memberships 0..2 of input 1 active.
  - Bits [5:3]: memberships 0..2 of input 2 active.
- `regra`  out  4: rule code `{sel_1[1:0], sel_2[1:0]}`.
- `regra_valida`  out  1: `regra` is meaningful this cycle.
- `reset_inf`  out  1: one-cycle clear of the inference accumulators.
- `ocupado`  out  1: scan in progress (LIMPA through FIM).
- `fim`  out  1: one-cycle end-of-scan pulse.

## Operation
- States: IDLE, LIMPA, VARRE, FIM.
- IDLE
  - All outputs 0.
  - If `inicio`=1: latch `Ativo` into `mask_r` and go to LIMPA.
- LIMPA
  - Lasts 1 cycle; `reset_inf`=1, `ocupado`=1.
  - Search for the first eligible pair. If found, go to VARRE; otherwise go to FIM.
- VARRE
  - `regra_valida`=1 and `regra`=`{i,j}` for the current pair.
  - A hold counter counts from 0 to CICLOS_REGRA-1.
  - On the last hold cycle, advance to the next eligible pair. If there is none, go to FIM.
- FIM
  - Lasts 1 cycle; `fim`=1, `ocupado`=1, `regra_valida`=0. Then go to IDLE.
- Pair order: i (input-1 index) is the outer loop 0..2 and j is the inner loop 0..2. Rule codes in order: 0,1,2,4,5,6,8,9,10. Codes 3, 7, 11..15 are never emitted.
- A pair (i,j) is eligible when `mask_r[i]` and `mask_r[3+j]` are both 1 (only when the skip feature is compiled in; see Configuration).
- Next-pair search is a combinational priority search over the pairs after the current one. It costs no extra cycle.
- `mask_r` is frozen for the whole scan; changes on `Ativo` after the start are ignored.
- `inicio` outside IDLE is ignored, with no queuing.
- `aborta`=1 in any non-IDLE state: go to IDLE on the next edge with all outputs 0. No `fim` pulse is produced. `aborta` takes priority over every other transition.
- `inicio` and `aborta` both high while in IDLE: stay in IDLE.
- Arithmetic:
  - Hold counter is 4 bits.
  - Pair indices are 2 bits each, saturating at 2.
  - The index increment wraps j from 2 to 0 and increments i at the same time.

## Timing
- All outputs are registered.
- Reset values: `regra`=0, `regra_valida`=0, `reset_inf`=0, `ocupado`=0, `fim`=0; state is IDLE; counters and `mask_r` are 0.
- Cycle-by-cycle, with `inicio` sampled at edge 0:
  - Cycle 1: `reset_inf` high.
  - First rule valid from cycle 2.
  - Each rule is valid for exactly CICLOS_REGRA cycles, back-to-back with no gap.
- With N eligible pairs, `fim` is high in cycle 2+N·CICLOS_REGRA.
- The block returns to IDLE one cycle after `fim`. It can accept a new `inicio` on the edge that ends the `fim` cycle + 1, i.e. `inicio` held high then starts the next scan.
- With N=0, `fim` is high in cycle 2.
- Asserting `Srst` mid-scan forces the reset values immediately, with no `fim` pulse.

## Configuration
- Macro: `ESCALONADOR_SALTO_EN`.
- Defined: inactive pairs are skipped per the eligibility rule; N ranges 0..9.
- Undefined: `mask_r` is treated as all-ones. All 9 pairs are scanned regardless of `Ativo`, so N=9 always. The latch still exists but drives no logic.

## Structure
- Shared package `fuzzy_pkg` holds:
  - state enum (IDLE/LIMPA/VARRE/FIM);
  - `N_PERT`=3 (memberships per input);
  - `W_REGRA`=4;
  - rule-code packing function `{i,j}`.
- Natural sub-module `busca_prox_par`: combinational next-eligible-pair finder. Inputs are `mask_r` and the current (i,j); outputs are `encontrado` and the next (i,j).

## Test plan
- Reset, all-active scan: `Srst` pulse, then `Ativo`=6'b111111, `inicio` 1 cycle, CICLOS_REGRA=2 → `reset_inf` in cycle 1; codes 0,0,1,1,2,2,4,4,…,10,10 in cycles 2..19; `fim` in cycle 20; `ocupado` high in cycles 1..20.
- Sparse mask: `Ativo`=6'b010_011 → with macro, codes 1,5 only and `fim` in cycle 6; without macro, all 9 codes and `fim` in cycle 20.
- Empty half: `Ativo`=6'b000_111 with macro → `reset_inf` in cycle 1, `fim` in cycle 2, `regra_valida` never high.
- Mask change and re-start during scan: toggle `Ativo` and pulse `inicio` in cycle 5 → sequence unchanged from the latched mask; no second scan starts.
- Abort: `aborta` in cycle 7 → all outputs 0 from cycle 8, no `fim`. A new `inicio` in cycle 9 → `reset_inf` in cycle 10.
- Async reset mid-rule: `Srst` asserted between edges in cycle 4 → `regra_valida`/`ocupado` drop to 0 before the next edge; the block stays idle after release.
